// File: rtl/idct_zigzag_loader.sv
`default_nettype none
// ============================================================================
// Module   : idct_zigzag_loader
// Brief    : Zigzag-to-raster coefficient loader with ping-pong banks feeding
//            a 64-lane IDCT input bus. Optional end-of-block input under the
//            IDCT_LOADER_EOB_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module idct_zigzag_loader #(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    coef_in,
    input  logic                 coef_valid,
    output logic                 coef_ready,
`ifdef IDCT_LOADER_EOB_EN
    input  logic                 coef_eob,
`endif
    output logic [64*DATA_W-1:0] blk_out,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [15:0]          blk_count
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } bank_state_t;

    // Zigzag scan position -> natural row-major lane index.
    localparam logic [5:0] c_zigzag [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DATA_W-1:0] r_bank [2][64];
    bank_state_t       r_state [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [5:0]        r_wr_idx;
    logic [15:0]       r_blk_count;
    logic              r_active;

    logic w_accept;
    logic w_drain;
    logic w_eob;
    logic w_last;

`ifdef IDCT_LOADER_EOB_EN
    assign w_eob = coef_eob;
`else
    assign w_eob = 1'b0;
`endif

    // r_active keeps coef_ready low while reset is held and releases it one cycle later.
    assign coef_ready = r_active & (r_state[r_wr_bank] != ST_FULL);
    assign blk_valid  = (r_state[r_rd_bank] == ST_FULL);
    assign blk_count  = r_blk_count;

    assign w_accept = coef_valid & coef_ready;
    assign w_drain  = blk_valid & blk_ready;
    assign w_last   = (r_wr_idx == 6'd63) | w_eob;

    // Accept targets a non-FULL bank and drain a FULL one, so they never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank[0]   <= '{default: '0};
            r_bank[1]   <= '{default: '0};
            r_state[0]  <= ST_EMPTY;
            r_state[1]  <= ST_EMPTY;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= 6'd0;
            r_blk_count <= 16'd0;
            r_active    <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_drain) begin
                r_bank[r_rd_bank]  <= '{default: '0};
                r_state[r_rd_bank] <= ST_EMPTY;
                r_rd_bank          <= ~r_rd_bank;
                r_blk_count        <= r_blk_count + 16'd1;
            end
            if (w_accept) begin
                r_bank[r_wr_bank][c_zigzag[r_wr_idx]] <= coef_in;
                if (w_last) begin
                    r_state[r_wr_bank] <= ST_FULL;
                    r_wr_idx           <= 6'd0;
                    r_wr_bank          <= ~r_wr_bank;
                end else begin
                    r_state[r_wr_bank] <= ST_FILLING;
                    r_wr_idx           <= r_wr_idx + 6'd1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < 64; k++) begin : g_lane
            assign blk_out[k*DATA_W +: DATA_W] = r_bank[r_rd_bank][k];
        end
    endgenerate

endmodule
`default_nettype wire
